// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between the memory stage and a single-port,
// word-addressed data memory. Loads own the port; stores drain when it is idle.
// Optional feature macro: STORE_FORWARD_EN. When it is defined, a load that hits
// a pending store takes its data from the youngest matching entry. When it is
// undefined, a load that hits stalls while the buffer drains.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     mem_we,
  output logic [AW-1:0]            mem_a,
  output logic [DW-1:0]            mem_wd,
  input  logic [DW-1:0]            mem_rd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = AW - 2;

  logic [IW-1:0] ent_addr [DEPTH];
  logic [DW-1:0] ent_data [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] cnt;
  logic          push, pop, hit;
  logic [DW-1:0] hit_data;

  // The byte offset of a store is irrelevant to a word-addressed memory.
  logic unused_st_offset;
  assign unused_st_offset = ^st_addr[1:0];

  assign st_ready = (cnt < CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign push     = st_valid && st_ready && !reset;
  assign pop      = mem_we;

  // Search the pending entries from oldest to youngest so the youngest hit wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < cnt) && (ent_addr[head + PW'(i)] == ld_addr[AW-1:2])) begin
        hit      = 1'b1;
        hit_data = ent_data[head + PW'(i)];
      end
    end
  end

  // Port arbitration and load result; everything is held quiet during reset so
  // that discarded stores never reach memory.
  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    ld_data  = '0;
    ld_stall = 1'b0;
    if (!reset) begin
      if (ld_valid) begin
`ifdef STORE_FORWARD_EN
        mem_a   = ld_addr;
        ld_data = hit ? hit_data : mem_rd;
`else
        if (hit) begin
          // Drain through the hazard; the load retries once no match remains.
          ld_stall = 1'b1;
          mem_we   = 1'b1;
          mem_a    = {ent_addr[head], 2'b00};
          mem_wd   = ent_data[head];
        end else begin
          mem_a   = ld_addr;
          ld_data = mem_rd;
        end
`endif
      end else if (cnt != '0) begin
        mem_we = 1'b1;
        mem_a  = {ent_addr[head], 2'b00};
        mem_wd = ent_data[head];
      end
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Entry storage; contents are only visible through valid entries.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr[AW-1:2];
      ent_data[tail] <= st_data;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a write scoreboard and a memory model.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid, ld_valid;
  logic [31:0] st_addr, st_data, ld_addr, ld_data;
  logic        st_ready, ld_stall, empty, mem_we;
  logic [2:0]  count;
  logic [31:0] mem_a, mem_wd, mem_rd;

  typedef struct packed { logic [31:0] a; logic [31:0] d; } wr_t;
  wr_t         expq[$];
  logic [31:0] mem [256];
  int          errors = 0;
  int          checks = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_addr(st_addr),
    .st_data(st_data), .st_ready(st_ready), .ld_valid(ld_valid),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_stall(ld_stall), .empty(empty),
    .count(count), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!empty && n < 20) begin
      cyc();
      n++;
    end
    chk("drain_timeout", empty, 1);
  endtask

  // Accepted stores enter the scoreboard; reset discards them.
  always @(posedge clk) begin
    if (reset) expq.delete();
    else if (st_valid && st_ready) expq.push_back({st_addr[31:2], 2'b00, st_data});
  end

  // Memory commits on negedge; every write must be the oldest expected store.
  always @(negedge clk) begin
    if (mem_we) begin
      chk("wr_expected", expq.size() != 0, 1);
      if (expq.size() != 0) begin
        wr_t e;
        e = expq.pop_front();
        chk("wr_addr", mem_a, e.a);
        chk("wr_data", mem_wd, e.d);
      end
      mem[mem_a[9:2]] = mem_wd;
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1; st_valid = 1'b0; ld_valid = 1'b0;
    st_addr = '0; st_data = '0; ld_addr = '0;
    cyc(); cyc();
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("idle_count", count, 0);
      chk("idle_empty", empty, 1);
      chk("idle_ready", st_ready, 1);
      chk("idle_we", mem_we, 0);
      chk("idle_mema", mem_a, 0);
      chk("idle_ld", {ld_stall, ld_data}, 0);
    end

    // Back-to-back stores with the port free: each drains the next cycle
    st_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_addr = 32'(4 * i);
      st_data = 32'(8'h11 * (i + 1));
      #1;
      if (i > 0) chk("b2b_count", count, 1);
      chk("b2b_we", mem_we, i > 0);
      cyc();
    end
    st_valid = 1'b0;
    #1;
    chk("b2b_last_count", count, 1);
    chk("b2b_last_we", mem_we, 1);
    cyc();
    chk("b2b_empty", empty, 1);
    for (int i = 0; i < 4; i++) chk("b2b_mem", mem[i], 32'(8'h11 * (i + 1)));

    // Plain load miss reads memory combinationally
    ld_valid = 1'b1; ld_addr = 32'h04;
    #1;
    chk("miss_data", ld_data, 32'h22);
    chk("miss_stall", ld_stall, 0);
    chk("miss_mema", mem_a, 32'h04);
    cyc();

    // Load holds the port while the buffer fills; fifth store waits
    ld_addr = 32'h40; st_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      st_addr = 32'h20 + 32'(4 * i);
      st_data = 32'h101 + 32'(i);
      #1;
      chk("fill_ready", st_ready, 1);
      chk("fill_count", count, 3'(i));
      chk("fill_we", mem_we, 0);
      cyc();
    end
    st_addr = 32'h30; st_data = 32'h105;
    #1;
    chk("full_ready", st_ready, 0);
    chk("full_count", count, 4);
    chk("full_ld", ld_data, 0);
    cyc();
    chk("full_hold_ready", st_ready, 0);
    chk("full_hold_we", mem_we, 0);
    // Release the load: drain while full, store still refused
    ld_valid = 1'b0;
    #1;
    chk("full_drain_ready", st_ready, 0);
    chk("full_drain_we", mem_we, 1);
    chk("full_drain_a", mem_a, 32'h20);
    cyc();
    // Load back on; fifth store accepted without a pop
    ld_valid = 1'b1;
    #1;
    chk("refill_count", count, 3);
    chk("refill_ready", st_ready, 1);
    chk("refill_we", mem_we, 0);
    cyc();
    st_valid = 1'b0; ld_valid = 1'b0;
    #1;
    chk("refill_count4", count, 4);
    wait_empty();
    chk("fifth_mem", mem[12], 32'h105);

    // Load hit on two pending stores to the same word
    ld_valid = 1'b1; ld_addr = 32'h40;
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA;
    cyc();
    st_data = 32'hBBBB;
    cyc();
    st_valid = 1'b0; ld_addr = 32'h12;
    #1;
`ifdef STORE_FORWARD_EN
    chk("fwd_data", ld_data, 32'hBBBB);
    chk("fwd_stall", ld_stall, 0);
    chk("fwd_we", mem_we, 0);
    cyc();
    ld_valid = 1'b0;
    wait_empty();
`else
    chk("stall0", ld_stall, 1);
    chk("stall0_data", ld_data, 0);
    chk("stall0_we", mem_we, 1);
    chk("stall0_wd", mem_wd, 32'hAAAA);
    cyc();
    chk("stall1", ld_stall, 1);
    chk("stall1_wd", mem_wd, 32'hBBBB);
    cyc();
    chk("stall_done", ld_stall, 0);
    chk("stall_data", ld_data, 32'hBBBB);
    chk("stall_we", mem_we, 0);
    chk("stall_count", count, 0);
    cyc();
    ld_valid = 1'b0;
`endif
    chk("hit_mem", mem[4], 32'hBBBB);

    // Reset with three pending stores: nothing reaches memory
    ld_valid = 1'b1; ld_addr = 32'h40; st_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_addr = 32'h50 + 32'(4 * i);
      st_data = 32'hDEAD0 + 32'(i);
      cyc();
    end
    st_valid = 1'b0; ld_valid = 1'b0; reset = 1'b1;
    #1;
    chk("rst_count_before", count, 3);
    chk("rst_we_during", mem_we, 0);
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst_count", count, 0);
      chk("rst_we", mem_we, 0);
      cyc();
    end
    for (int i = 0; i < 3; i++) chk("rst_mem", mem[20 + i], 0);
    chk("sb_empty", expq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the CPU memory-access stage and the word-addressed data memory. It queues stores in a DEPTH-entry FIFO, drains one store per cycle into the memory's single port when no load needs that port, and gives loads priority. Loads that hit a pending store are either forwarded from the buffer or stalled until it drains, depending on configuration. Memory read is combinational; memory writes commit on the negative clock edge.

## Interface
- DEPTH, 4: number of store entries; power of two, ≥2.
- AW, 32: address width (byte address; word index = addr[AW-1:2]).
- DW, 32: data width.

- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- st_valid  in  1  store request from memory stage.
- st_addr  in  AW  store byte address.
- st_data  in  DW  store data.
- st_ready  out  1  buffer can accept a store this cycle.
- ld_valid  in  1  load request from memory stage.
- ld_addr  in  AW  load byte address.
- ld_data  out  DW  load result, combinational.
- ld_stall  out  1  load cannot complete this cycle; pipeline holds the request.
- empty  out  1  no pending stores (used for fences/halt).
- count  out  $clog2(DEPTH)+1  number of pending stores.
- mem_we  out  1  write enable to data memory.
- mem_a  out  AW  data-memory address.
- mem_wd  out  DW  data-memory write data.
- mem_rd  in  DW  data-memory read data (combinational).

## Operation
- State: DEPTH entries {addr word index, data}, head/tail pointers (wrap modulo DEPTH), count.
- Push: st_valid && st_ready at posedge → entry written at tail, tail+1. st_valid while !st_ready is ignored (requester must hold).
- st_ready = (count < DEPTH); depends on registered count only — no same-cycle push/pop bypass when full.
- Port arbitration, per cycle, combinational:
  - ld_valid=1 → mem_a=ld_addr, mem_we=0 (load owns port, drain paused).
  - else if count>0 → mem_a={head addr,2'b00}, mem_wd=head data, mem_we=1; pop at posedge.
  - else mem_we=0, mem_a=0, mem_wd=0.
- Load hit: pending entry whose word index equals ld_addr[AW-1:2]. Match against youngest such entry.
- Load result without hit: ld_data=mem_rd, ld_stall=0.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Simultaneous st_valid and ld_valid: store enqueued; load does not see that store (sees older state only).
- ld_valid=0 → ld_data=0, ld_stall=0.

## Timing
- Reset values: count=0, empty=1, st_ready=1, ld_stall=0, mem_we=0, mem_a=0, mem_wd=0, ld_data=0; head=tail=0. Entry contents undefined, never observable.
- Reset mid-operation: all pending stores discarded, none written to memory.
- Store latency: accepted at posedge N → earliest mem_we=1 in cycle N+1 (posedge N to N+1), committed at that cycle's negedge.
- Drain throughput: 1 store/cycle while ld_valid=0.
- Load latency: 0 cycles (combinational) when not stalled.
- count/empty update only at posedge.

## Configuration
- STORE_FORWARD_EN defined: load hit returns youngest matching entry data, ld_stall=0; load still occupies the port (drain paused).
- Undefined: load hit → ld_stall=1, ld_data=0, and the drain runs despite ld_valid (mem_a=head address, mem_we=1) until no matching entry remains; the stalled load then reads mem_rd on the first cycle without a hit.

## Test plan
- Reset then idle → count=0, empty=1, st_ready=1, mem_we=0 for 5 cycles; reset asserted with 3 pending stores → no mem_we after reset, count=0.
- Push 4 stores (0x00←0x11, 0x04←0x22, 0x08←0x33, 0x0C←0x44) back-to-back with ld_valid=0 → mem_we pulses cycles 1–4 in that order, memory holds values, empty=1 after cycle 4.
- Hold ld_valid=1 to 0x40 while pushing 5 stores → st_ready=0 after 4th, 5th held; count=4; releasing load drains 1/cycle, 5th accepted next cycle.
- STORE_FORWARD_EN: stores 0x10←0xAAAA then 0x10←0xBBBB pending, load 0x12 → ld_data=0xBBBB, ld_stall=0, mem_we=0.
- Without macro: same setup → ld_stall=1 for 2 cycles while both drain, then ld_data=0xBBBB from memory.
- Full buffer, simultaneous drain and st_valid → st_ready=0, store not taken that cycle; accepted next cycle, count returns to 4.
